mem_arbiter: RTL and testbench

- Sequences the single byte-wide RAM port between two requesters:
  - instruction fetch (IF), which reads 32-bit words;
  - the MEM stage, which performs the loads and stores whose address and data come from the execute stage.
- Assembles multi-byte reads and splits multi-byte writes into byte transfers.
- Arbitrates with fixed priority. Supports cancelling an in-flight fetch on branch mispredict or JALR redirect.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_byte_assembler.sv | 42 ++++
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM arbiter: transfer lengths, FSM states
// and default geometry.
package mem_arbiter_pkg;

    localparam int RAM_AW_DEF = 17;
    localparam int RD_LAT_DEF = 1;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_MEM_RD,
        ST_MEM_WR
    } state_t;

    // The reserved length code behaves like a word access.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Collects bytes returned by the RAM into little-endian lanes of a 32-bit word;
// lanes never written stay zero because the word is cleared on acceptance.
module mem_byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        capture,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    output logic [31:0] word
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [31:0] merged;

    // word includes the byte arriving this cycle so the final byte can be
    // delivered on the same edge it is captured.
    always_comb begin
        merged = acc_q;
        if (capture) begin
            case (lane)
                2'd0:    merged[7:0]   = din;
                2'd1:    merged[15:8]  = din;
                2'd2:    merged[23:16] = din;
                default: merged[31:24] = din;
            endcase
        end
        acc_d = clear ? 32'd0 : merged;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= 32'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign word = merged;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// MEM stage, splitting stores and assembling loads/fetches byte by byte.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [RAM_AW-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic              accept_mem, accept_if, last_rd, last_wr;
    logic [RAM_AW-1:0] next_a;
    logic              asm_clear, asm_capture;
    logic [1:0]        asm_lane, wr_idx;
    logic [31:0]       asm_word;
    logic [7:0]        wr_byte;
    logic              unused_addr_hi;

    // A requester whose done pulse is showing still holds req, so it is masked for that edge.
    assign accept_mem = mem_req && !mem_done_q;
    assign accept_if  = if_req && !if_cancel && !if_done_q;

    assign last_rd     = (int'(cnt_q) == int'(nbytes_q) + RD_LAT - 1);
    assign last_wr     = ((cnt_q + 3'd1) == nbytes_q);
    assign next_a      = base_q + RAM_AW'(cnt_q) + RAM_AW'(1);
    assign asm_capture = ((state_q == ST_IF_RD) || (state_q == ST_MEM_RD)) && (int'(cnt_q) >= RD_LAT);
    assign asm_lane    = 2'(cnt_q - 3'(RD_LAT));
    assign wr_idx      = 2'(cnt_q + 3'd1);

    always_comb begin
        case (wr_idx)
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    assign unused_addr_hi = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_mem) begin
                    state_d = mem_we ? ST_MEM_WR : ST_MEM_RD;
                end else if (accept_if) begin
                    state_d = ST_IF_RD;
                end
            end
            ST_IF_RD:  if (if_cancel || last_rd) state_d = ST_IDLE;
            ST_MEM_RD: if (last_rd) state_d = ST_IDLE;
            ST_MEM_WR: if (last_wr) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q + 3'd1;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        asm_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                if (accept_mem) begin
                    base_d    = mem_addr[RAM_AW-1:0];
                    nbytes_d  = len_bytes(mem_len);
                    wdata_d   = mem_wdata;
                    ram_a_d   = mem_addr[RAM_AW-1:0];
                    asm_clear = 1'b1;
                    if (mem_we) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end
                end else if (accept_if) begin
                    base_d    = if_addr[RAM_AW-1:0];
                    nbytes_d  = 3'd4;
                    ram_a_d   = if_addr[RAM_AW-1:0];
                    asm_clear = 1'b1;
                end
            end
            ST_IF_RD, ST_MEM_RD: begin
                ram_a_d = next_a;
                // A cancelled fetch drops whatever byte is still in flight.
                if (last_rd && !((state_q == ST_IF_RD) && if_cancel)) begin
                    if (state_q == ST_IF_RD) begin
                        if_done_d = 1'b1;
                        if_data_d = asm_word;
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = asm_word;
                    end
                end
            end
            ST_MEM_WR: begin
                if (last_wr) begin
                    mem_done_d = 1'b1;
                end else begin
                    ram_a_d    = next_a;
                    ram_dout_d = wr_byte;
                    ram_wr_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    mem_byte_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .capture (asm_capture),
        .lane    (asm_lane),
        .din     (ram_din),
        .word    (asm_word)
    );

    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte RAM model plus a per-cycle expectation table
// built from transaction-level timing rules, compared every negative edge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW   = 17;
    localparam int MAXE = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_cancel, mem_req, mem_we;
    logic [31:0]   if_addr, mem_addr, mem_wdata;
    logic [1:0]    mem_len;
    logic          if_done, mem_done, ram_wr, busy;
    logic [31:0]   if_data, mem_rdata;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din = 8'd0;

    mem_arbiter #(.RAM_AW(AW), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_cancel (if_cancel),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM: synchronous read, one cycle latency.
    logic [7:0] ram     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_din <= ram[ram_a];
        if (ram_wr) ram[ram_a] <= ram_dout;
    end

    // Expected outputs per edge index (value seen after that edge).
    bit            exp_busy [MAXE];
    bit            exp_wr   [MAXE];
    bit            exp_a_v  [MAXE];
    logic [AW-1:0] exp_a    [MAXE];
    logic [7:0]    exp_d    [MAXE];
    bit            exp_ifd  [MAXE];
    logic [31:0]   exp_ifw  [MAXE];
    bit            exp_md   [MAXE];
    bit            exp_mld  [MAXE];
    logic [31:0]   exp_mw   [MAXE];
    logic [31:0]   model_if_data  = 32'd0;
    logic [31:0]   model_mem_data = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lenBytes(input logic [1:0] len);
        if (len == 2'd0) return 1;
        if (len == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] modelRead(input logic [AW-1:0] base, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_mem[AW'(base + k)];
        return w;
    endfunction

    task automatic schedRead(input bit is_mem, input int acc, input logic [AW-1:0] base, input int n);
        for (int k = 0; k <= n; k++) exp_busy[acc+k] = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_a_v[acc+k] = 1'b1;
            exp_a[acc+k]   = AW'(base + k);
        end
        if (is_mem) begin
            exp_md[acc+n+1]  = 1'b1;
            exp_mld[acc+n+1] = 1'b1;
            exp_mw[acc+n+1]  = modelRead(base, n);
        end else begin
            exp_ifd[acc+n+1] = 1'b1;
            exp_ifw[acc+n+1] = modelRead(base, n);
        end
    endtask

    task automatic schedWrite(input int acc, input logic [AW-1:0] base, input int n, input logic [31:0] wd);
        for (int k = 0; k < n; k++) begin
            exp_busy[acc+k] = 1'b1;
            exp_wr[acc+k]   = 1'b1;
            exp_a[acc+k]    = AW'(base + k);
            exp_d[acc+k]    = wd[8*k +: 8];
        end
        exp_md[acc+n] = 1'b1;
    endtask

    task automatic modelReset(input int from);
        for (int e = from; e < MAXE; e++) begin
            exp_busy[e] = 1'b0; exp_wr[e] = 1'b0; exp_a_v[e] = 1'b0;
            exp_ifd[e]  = 1'b0; exp_md[e] = 1'b0; exp_mld[e] = 1'b0;
        end
        model_if_data  = 32'd0;
        model_mem_data = 32'd0;
    endtask

    // Compare process: every negative edge, DUT against the expectation table.
    always @(negedge clk) begin
        if (cyc < MAXE) begin
            checkOutput("busy", 32'(busy), 32'(exp_busy[cyc]));
            checkOutput("ram_wr", 32'(ram_wr), 32'(exp_wr[cyc]));
            if (exp_wr[cyc]) begin
                checkOutput("wr_addr", 32'(ram_a), 32'(exp_a[cyc]));
                checkOutput("wr_data", 32'(ram_dout), 32'(exp_d[cyc]));
                ref_mem[exp_a[cyc]] = exp_d[cyc];
            end
            if (exp_a_v[cyc]) checkOutput("rd_addr", 32'(ram_a), 32'(exp_a[cyc]));
            checkOutput("if_done", 32'(if_done), 32'(exp_ifd[cyc]));
            if (exp_ifd[cyc]) model_if_data = exp_ifw[cyc];
            checkOutput("if_data", if_data, model_if_data);
            checkOutput("mem_done", 32'(mem_done), 32'(exp_md[cyc]));
            if (exp_mld[cyc]) model_mem_data = exp_mw[cyc];
            checkOutput("mem_rdata", mem_rdata, model_mem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic presetByte(input logic [AW-1:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // One transaction from an idle controller; req held through the ignored done edge.
    task automatic applyStimulus(input bit is_mem, input bit we, input logic [1:0] len,
                                 input logic [31:0] addr, input logic [31:0] wd);
        int acc, n, done_e;
        n   = is_mem ? lenBytes(len) : 4;
        acc = cyc + 1;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if (is_mem && we) begin
            schedWrite(acc, AW'(addr), n, wd);
            done_e = acc + n;
        end else begin
            schedRead(is_mem, acc, AW'(addr), n);
            done_e = acc + n + 1;
        end
        while (cyc < done_e + 1) tick();
        mem_req = 1'b0;
        if_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e, acc;
        rst = 1'b0; if_req = 1'b0; if_cancel = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        presetByte(17'h00100, 8'h13); presetByte(17'h00101, 8'h05);
        presetByte(17'h00102, 8'h10); presetByte(17'h00103, 8'h00);
        presetByte(17'h00000, 8'h6F); presetByte(17'h00001, 8'h00);
        presetByte(17'h00002, 8'h40); presetByte(17'h00003, 8'h00);
        presetByte(17'h00300, 8'h80); presetByte(17'h00301, 8'h5A);
        presetByte(17'h1FFFF, 8'h34);

        repeat (3) tick();
        checkOutput("rst_ram_a", 32'(ram_a), 32'h0);
        checkOutput("rst_ram_wr", 32'(ram_wr), 32'h0);
        checkOutput("rst_ram_dout", 32'(ram_dout), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_if_data", if_data, 32'h0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b1;
        tick();

        $display("[TB] IF word read at 0x100");
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h100, 32'd0);
        checkOutput("if_word_lit", if_data, 32'h00100513);

        $display("[TB] store word 0xDEADBEEF at 0x204, read back");
        applyStimulus(1'b1, 1'b1, LEN_W, 32'h204, 32'hDEADBEEF);
        checkOutput("st_b0_lit", 32'(ram[17'h204]), 32'hEF);
        checkOutput("st_b1_lit", 32'(ram[17'h205]), 32'hBE);
        checkOutput("st_b2_lit", 32'(ram[17'h206]), 32'hAD);
        checkOutput("st_b3_lit", 32'(ram[17'h207]), 32'hDE);
        applyStimulus(1'b1, 1'b0, LEN_W, 32'h204, 32'd0);
        checkOutput("ld_word_lit", mem_rdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, LEN_H, 32'h205, 32'd0);
        checkOutput("ld_half_unal_lit", mem_rdata, 32'h0000ADBE);
        applyStimulus(1'b1, 1'b1, LEN_B, 32'h500, 32'h777777A5);
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h500, 32'd0);
        checkOutput("st_byte_lit", mem_rdata, 32'h000000A5);

        $display("[TB] simultaneous IF and MEM requests");
        e = cyc;
        if_req = 1'b1; if_addr = 32'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = LEN_B; mem_addr = 32'h300;
        schedRead(1'b1, e + 1, 17'h300, 1);
        schedRead(1'b0, e + 4, 17'h0, 4);
        while (cyc < e + 4) tick();
        mem_req = 1'b0;
        checkOutput("simul_load_lit", mem_rdata, 32'h00000080);
        while (cyc < e + 10) tick();
        if_req = 1'b0;
        checkOutput("simul_fetch_lit", if_data, 32'h0040006F);

        $display("[TB] cancel a fetch two cycles in");
        e = cyc;
        acc = e + 1;
        if_req = 1'b1; if_addr = 32'h100;
        exp_busy[acc] = 1'b1; exp_busy[acc+1] = 1'b1;
        exp_a_v[acc] = 1'b1;   exp_a[acc]   = 17'h100;
        exp_a_v[acc+1] = 1'b1; exp_a[acc+1] = 17'h101;
        while (cyc < acc + 1) tick();
        if_cancel = 1'b1; if_req = 1'b0;
        tick();
        if_cancel = 1'b0;
        checkOutput("cancel_idle_lit", 32'(busy), 32'h0);
        applyStimulus(1'b1, 1'b0, LEN_B, 32'h301, 32'd0);
        checkOutput("after_cancel_lit", mem_rdata, 32'h0000005A);
        checkOutput("if_hold_lit", if_data, 32'h0040006F);

        $display("[TB] half load wrapping past the top of RAM");
        applyStimulus(1'b1, 1'b0, LEN_H, 32'hFFFFFFFF, 32'd0);
        checkOutput("wrap_lit", mem_rdata, 32'h00006F34);

        $display("[TB] async reset in the middle of a store");
        e = cyc;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = LEN_W; mem_addr = 32'h400; mem_wdata = 32'h11223344;
        schedWrite(e + 1, 17'h400, 4, 32'h11223344);
        while (cyc < e + 3) tick();
        rst = 1'b0;
        mem_req = 1'b0;
        modelReset(cyc);
        #1;
        checkOutput("arst_ram_wr", 32'(ram_wr), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_ram_a", 32'(ram_a), 32'h0);
        checkOutput("arst_ram_dout", 32'(ram_dout), 32'h0);
        checkOutput("arst_mem_done", 32'(mem_done), 32'h0);
        checkOutput("arst_mem_rdata", mem_rdata, 32'h0);
        checkOutput("arst_if_data", if_data, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, LEN_W, 32'h400, 32'd0);
        checkOutput("partial_store_lit", mem_rdata, 32'h00003344);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
